// File: rtl/dict_ram_arbiter.sv
// Dictionary RAM arbiter: shares one single-port RAM between the LZW core (port 0) and the
// host port (port 1) round-robin, and sweeps hash entries invalid on a dictionary clear.
module dict_ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int CLEAR_BASE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic                  r0_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rhit,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rhit,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_clr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // Sweep counter is one bit wider than the address so the top entry is written before it stops.
    localparam logic [ADDR_WIDTH:0] CLR_FIRST = (ADDR_WIDTH+1)'(CLEAR_BASE);
    localparam logic [ADDR_WIDTH:0] CLR_TERM  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CLR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_reg, state_next;
    logic                  rr_ptr_reg;
    logic [ADDR_WIDTH:0]   clr_cnt_reg;
    logic                  r0_gnt_reg, r1_gnt_reg;
    logic                  r0_rvalid_reg, r1_rvalid_reg;
    logic                  ram_cs_reg, ram_we_reg, ram_clr_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [DATA_WIDTH-1:0] ram_data_in_reg;
    logic                  clear_busy_reg, clear_done_reg;

    logic arb_open, lock_hold, grant0, grant1;

    // rr_ptr_reg is the port favoured on a tie; it is 1 exactly when port 0 was granted last.
    always_comb begin
        arb_open  = (state_reg != ST_CLEAR) && !clear_start;
        lock_hold = r0_lock && rr_ptr_reg;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (arb_open) begin
            if (r0_req && r1_req && !lock_hold) begin
                grant0 = !rr_ptr_reg;
                grant1 = rr_ptr_reg;
            end else if (r0_req) begin
                grant0 = 1'b1;
            end else if (r1_req && !lock_hold) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (clr_cnt_reg == CLR_TERM) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                if (clear_start) begin
                    state_next = ST_CLEAR;
                end else if (grant0 || grant1) begin
                    state_next = ST_SERVE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= 1'b0;
            clr_cnt_reg     <= CLR_FIRST;
            r0_gnt_reg      <= 1'b0;
            r1_gnt_reg      <= 1'b0;
            r0_rvalid_reg   <= 1'b0;
            r1_rvalid_reg   <= 1'b0;
            ram_cs_reg      <= 1'b0;
            ram_we_reg      <= 1'b0;
            ram_clr_reg     <= 1'b0;
            ram_addr_reg    <= '0;
            ram_data_in_reg <= '0;
            clear_busy_reg  <= 1'b0;
            clear_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            r0_gnt_reg     <= grant0;
            r1_gnt_reg     <= grant1;
            // The owner tag is simply last cycle's grant; RAM data lands one cycle after the command.
            r0_rvalid_reg  <= r0_gnt_reg && !ram_we_reg;
            r1_rvalid_reg  <= r1_gnt_reg && !ram_we_reg;
            clear_done_reg <= 1'b0;
            if (grant0 || grant1) begin
                rr_ptr_reg <= grant0;
            end
            if (state_reg == ST_CLEAR) begin
                ram_we_reg <= 1'b0;
                if (clr_cnt_reg == CLR_TERM) begin
                    ram_cs_reg     <= 1'b0;
                    ram_clr_reg    <= 1'b0;
                    clear_busy_reg <= 1'b0;
                    clear_done_reg <= 1'b1;
                    clr_cnt_reg    <= CLR_FIRST;
                end else begin
                    ram_cs_reg   <= 1'b1;
                    ram_clr_reg  <= 1'b1;
                    ram_addr_reg <= clr_cnt_reg[ADDR_WIDTH-1:0];
                    clr_cnt_reg  <= clr_cnt_reg + CLR_ONE;
                end
            end else if (clear_start) begin
                ram_cs_reg     <= 1'b1;
                ram_clr_reg    <= 1'b1;
                ram_we_reg     <= 1'b0;
                ram_addr_reg   <= CLR_FIRST[ADDR_WIDTH-1:0];
                clr_cnt_reg    <= CLR_FIRST + CLR_ONE;
                clear_busy_reg <= 1'b1;
            end else begin
                ram_cs_reg      <= grant0 || grant1;
                ram_clr_reg     <= 1'b0;
                ram_we_reg      <= (grant0 && r0_we) || (grant1 && r1_we);
                ram_addr_reg    <= grant1 ? r1_addr : r0_addr;
                ram_data_in_reg <= grant1 ? r1_wdata : r0_wdata;
            end
        end
    end

    assign r0_gnt      = r0_gnt_reg;
    assign r1_gnt      = r1_gnt_reg;
    assign r0_rvalid   = r0_rvalid_reg;
    assign r1_rvalid   = r1_rvalid_reg;
    assign r0_rdata    = r0_rvalid_reg ? ram_data_out : '0;
    assign r1_rdata    = r1_rvalid_reg ? ram_data_out : '0;
    assign r0_rhit     = r0_rvalid_reg && ram_valid;
    assign r1_rhit     = r1_rvalid_reg && ram_valid;
    assign clear_busy  = clear_busy_reg;
    assign clear_done  = clear_done_reg;
    assign ram_cs      = ram_cs_reg;
    assign ram_we      = ram_we_reg;
    assign ram_clr     = ram_clr_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_data_in = ram_data_in_reg;

endmodule

// File: tb/tb_dict_ram_arbiter.sv
// Bench for dict_ram_arbiter: RAM environment, transaction-level model checked every cycle,
// and directed scenarios with literal expectations.
module tb_dict_ram_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 64;
    localparam int CB    = 256;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          clear_start = 1'b0;
    logic          r0_gnt, r0_rvalid, r0_rhit, r1_gnt, r1_rvalid, r1_rhit;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          clear_busy, clear_done, ram_cs, ram_we, ram_clr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;
    logic          ram_valid = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dict_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_BASE(CB)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_rhit(r0_rhit),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_rhit(r1_rhit),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_clr(ram_clr), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_valid(ram_valid)
    );

    function automatic logic [DW-1:0] pre(input int a);
        return {32'hC0DE_0000 | 32'(a), ~(32'(a) * 32'd7)};
    endfunction

    function automatic bit pre_valid(input int a);
        return (a < CB) || (a == 12'h2A0) || (a == 12'h100);
    endfunction

    // Single-port synchronous RAM with a per-entry valid bit
    logic [DW-1:0] ram_mem [DEPTH];
    logic          ram_vld [DEPTH];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_data_in;
                ram_vld[ram_addr] <= 1'b1;
            end else if (ram_clr) begin
                ram_vld[ram_addr] <= 1'b0;
            end else begin
                ram_data_out <= ram_mem[ram_addr];
                ram_valid    <= ram_vld[ram_addr];
            end
        end
    end

    // Model: dictionary contents plus who-was-served-last and a clear countdown
    logic [DW-1:0] m_data [DEPTH];
    bit            m_vld  [DEPTH];
    int            last_port = -1;
    bit            clearing  = 1'b0;
    int            clr_next  = 0;
    logic [DW-1:0] rd_data   = '0;
    bit            rd_hit    = 1'b0;
    bit            e_g0, e_g1, e_cs, e_we, e_clr, e_busy, e_done, e_rv0, e_rv1, e_hit;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rdata;
    int            cyc = 0;

    initial begin
        {e_g0, e_g1, e_cs, e_we, e_clr, e_busy, e_done, e_rv0, e_rv1, e_hit} = '0;
        e_addr = '0; e_din = '0; e_rdata = '0;
        forever begin
            bit mism;
            bit n_rv0, n_rv1;
            int win;
            bit c0, c1, w_we;
            int w_addr;
            logic [DW-1:0] w_data;
            @(negedge clk);
            cyc++;
            if (!rst) begin
                {e_g0, e_g1, e_cs, e_we, e_clr, e_busy, e_done, e_rv0, e_rv1, e_hit} = '0;
            end
            mism = (r0_gnt !== e_g0) || (r1_gnt !== e_g1) || (ram_cs !== e_cs) || (ram_we !== e_we) ||
                   (ram_clr !== e_clr) || (clear_busy !== e_busy) || (clear_done !== e_done) ||
                   (r0_rvalid !== e_rv0) || (r1_rvalid !== e_rv1) ||
                   (e_cs && (ram_addr !== e_addr)) || (e_we && (ram_data_in !== e_din)) ||
                   (e_rv0 && ((r0_rdata !== e_rdata) || (r0_rhit !== e_hit))) ||
                   (e_rv1 && ((r1_rdata !== e_rdata) || (r1_rhit !== e_hit)));
            n_vec++;
            if (mism) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got gnt=%b%b cs=%b we=%b clr=%b addr=%h din=%h busy=%b done=%b rv=%b%b rd0=%h/%b rd1=%h/%b, required gnt=%b%b cs=%b we=%b clr=%b addr=%h din=%h busy=%b done=%b rv=%b%b rd=%h/%b",
                         cyc, r0_gnt, r1_gnt, ram_cs, ram_we, ram_clr, ram_addr, ram_data_in, clear_busy, clear_done,
                         r0_rvalid, r1_rvalid, r0_rdata, r0_rhit, r1_rdata, r1_rhit,
                         e_g0, e_g1, e_cs, e_we, e_clr, e_addr, e_din, e_busy, e_done, e_rv0, e_rv1, e_rdata, e_hit);
            end
            if (r0_rvalid) $display("txn cycle %0d port0 read rdata=%h rhit=%b", cyc, r0_rdata, r0_rhit);
            if (r1_rvalid) $display("txn cycle %0d port1 read rdata=%h rhit=%b", cyc, r1_rdata, r1_rhit);
            if (clear_done) $display("txn cycle %0d dictionary clear complete", cyc);

            // Expected outputs for the next cycle from this cycle's inputs
            n_rv0 = e_g0 && !e_we;
            n_rv1 = e_g1 && !e_we;
            {e_g0, e_g1, e_cs, e_we, e_clr, e_busy, e_done} = '0;
            e_rv0 = n_rv0; e_rv1 = n_rv1;
            e_rdata = rd_data; e_hit = rd_hit;
            if (!rst) begin
                last_port = -1; clearing = 1'b0;
                e_rv0 = 1'b0; e_rv1 = 1'b0;
            end else if (clearing) begin
                if (clr_next < DEPTH) begin
                    e_cs = 1'b1; e_clr = 1'b1; e_busy = 1'b1; e_addr = AW'(clr_next);
                    m_vld[clr_next] = 1'b0;
                    clr_next++;
                end else begin
                    e_done = 1'b1;
                    clearing = 1'b0;
                end
            end else if (clear_start) begin
                clearing = 1'b1;
                e_cs = 1'b1; e_clr = 1'b1; e_busy = 1'b1; e_addr = AW'(CB);
                m_vld[CB] = 1'b0;
                clr_next = CB + 1;
            end else begin
                c0  = r0_req;
                c1  = r1_req && !(r0_lock && last_port == 0);
                win = -1;
                if (c0 && c1) win = (last_port == 0) ? 1 : 0;
                else if (c0)  win = 0;
                else if (c1)  win = 1;
                if (win >= 0) begin
                    w_we   = (win == 0) ? r0_we : r1_we;
                    w_addr = (win == 0) ? int'(r0_addr) : int'(r1_addr);
                    w_data = (win == 0) ? r0_wdata : r1_wdata;
                    e_g0 = (win == 0); e_g1 = (win == 1);
                    e_cs = 1'b1; e_we = w_we; e_addr = AW'(w_addr); e_din = w_data;
                    if (w_we) begin
                        m_data[w_addr] = w_data;
                        m_vld[w_addr]  = 1'b1;
                    end else begin
                        rd_data = m_data[w_addr];
                        rd_hit  = m_vld[w_addr];
                    end
                    last_port = win;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [4];
        int clr_cnt, done_cnt, early_gnt;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = pre(i);
            ram_vld[i] = pre_valid(i);
            m_data[i]  = pre(i);
            m_vld[i]   = pre_valid(i);
        end

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", 64'({r0_gnt, r1_gnt, ram_cs, ram_we, ram_clr, clear_busy, clear_done,
                                   r0_rvalid, r1_rvalid, r0_rhit, r1_rhit}), 64'd0);
        rst = 1'b1;
        tick();

        // First read after reset
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h100;
        tick();
        chk("first_gnt", 64'(r0_gnt), 64'd1);
        r0_req = 1'b0;
        tick();
        chk("first_rvalid", 64'(r0_rvalid), 64'd1);
        chk("first_rdata", r0_rdata, pre(12'h100));

        // Asynchronous reset in the middle of traffic
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 12'h041; r1_addr = 12'h2A0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("async_reset_ctl", 64'({r0_gnt, r1_gnt, ram_cs, ram_we, ram_clr, r0_rvalid, r1_rvalid}), 64'd0);
        chk("async_reset_addr", 64'(ram_addr), 64'd0);
        r0_req = 1'b0; r1_req = 1'b0;
        tick();
        rst = 1'b1;

        // Round-robin with both requesters held four cycles
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 12'h041; r1_addr = 12'h2A0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i] = r1_gnt ? 1 : (r0_gnt ? 0 : 9);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        chk("rr_grant0", 64'(seq[0]), 64'd0);
        chk("rr_grant1", 64'(seq[1]), 64'd1);
        chk("rr_grant2", 64'(seq[2]), 64'd0);
        chk("rr_grant3", 64'(seq[3]), 64'd1);
        tick();
        chk("rr_last_rvalid", 64'(r1_rvalid), 64'd1);
        chk("rr_last_rdata", r1_rdata, pre(12'h2A0));

        // Write then read back, port 0 then port 1
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h123; r0_wdata = 64'hDEADBEEF;
        tick();
        chk("wr0_gnt_we", 64'({r0_gnt, ram_we}), 64'd3);
        r0_we = 1'b0;
        tick();
        chk("rd0_gnt", 64'(r0_gnt), 64'd1);
        r0_req = 1'b0;
        tick();
        chk("rd0_rdata", r0_rdata, 64'hDEADBEEF);
        chk("rd0_rhit", 64'({r0_rvalid, r0_rhit}), 64'd3);
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'h200; r1_wdata = 64'h0123_4567_89AB_CDEF;
        tick();
        r1_we = 1'b0;
        tick();
        r1_req = 1'b0;
        tick();
        chk("rd1_rdata", r1_rdata, 64'h0123_4567_89AB_CDEF);

        // Lock: ignored while port 1 was last granted, then holds port 1 off
        r0_lock = 1'b1; r1_req = 1'b1; r1_addr = 12'h041;
        tick();
        chk("lock_ignored", 64'(r1_gnt), 64'd1);
        r0_req = 1'b1; r0_addr = 12'hFFE;
        tick();
        chk("lock_probe0", 64'({r0_gnt, r1_gnt}), 64'd2);
        r0_addr = 12'hFFF;
        tick();
        chk("lock_probe1", 64'({r0_gnt, r1_gnt}), 64'd2);
        r0_addr = 12'h100;
        tick();
        chk("lock_probe2", 64'({r0_gnt, r1_gnt}), 64'd2);
        r0_req = 1'b0;
        tick();
        chk("lock_hold_idle", 64'({r0_gnt, r1_gnt}), 64'd0);
        r0_lock = 1'b0;
        tick();
        chk("lock_release", 64'(r1_gnt), 64'd1);
        r1_req = 1'b0;
        tick();

        // Clear with a port-1 read in flight and a port-0 read waiting
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h2A0;
        tick();
        chk("inflight_gnt", 64'(r1_gnt), 64'd1);
        r1_req = 1'b0; clear_start = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h2A0;
        tick();
        clear_start = 1'b0;
        chk("inflight_rvalid", 64'({r1_rvalid, r1_rhit}), 64'd3);
        chk("inflight_rdata", r1_rdata, pre(12'h2A0));
        chk("clear_first_addr", 64'({ram_clr, ram_addr}), 64'h1100);
        clr_cnt = 1; done_cnt = 0; early_gnt = 0;
        for (int i = 0; i < 5000; i++) begin
            clear_start = (i == 100);
            tick();
            if (r0_gnt) early_gnt++;
            if (clear_done) begin
                done_cnt++;
                break;
            end
            if (ram_clr) clr_cnt++;
        end
        clear_start = 1'b0;
        chk("clear_cycles", 64'(clr_cnt), 64'd3840);
        chk("clear_done_seen", 64'(done_cnt), 64'd1);
        chk("no_gnt_during_clear", 64'(early_gnt), 64'd0);
        tick();
        chk("post_clear_gnt", 64'(r0_gnt), 64'd1);
        r0_req = 1'b0;
        tick();
        chk("cleared_entry_rhit", 64'({r0_rvalid, r0_rhit}), 64'd2);
        r0_req = 1'b1; r0_addr = 12'h041;
        tick();
        r0_req = 1'b0;
        tick();
        chk("ascii_entry_rhit", 64'({r0_rvalid, r0_rhit}), 64'd3);
        chk("ascii_entry_rdata", r0_rdata, pre(12'h041));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
